// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI NOR program-memory fetcher.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        CS_GAP,
        CMD,
        ADDR,
        DATA,
        HOLD
    } fetch_state_e;

    localparam logic [7:0] SPI_READ_CMD    = 8'h03;
    localparam int         FLASH_ADDR_BITS = 24;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 bit engine: SCK divider, MSB-first TX of up to 24 bits, 8-bit RX.
// tx_word is MSB-aligned; done is asserted in the cycle whose edge ends the last high phase.
module spi_shift_engine #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic [4:0]  len,
    input  logic [23:0] tx_word,
    input  logic        spi_miso,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        done,
    output logic [7:0]  rx_byte
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             busy_q, busy_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic [23:0]      tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [4:0]       bits_q, bits_d;

    // done depends only on flops so the owner may restart in the same cycle
    assign done     = busy_q && sck_q && (div_q == DIV_LAST) && (bits_q == 5'd1);
    assign spi_sck  = sck_q;
    assign spi_mosi = mosi_q;
    assign rx_byte  = rx_q;

    always_comb begin
        busy_d = busy_q;
        sck_d  = sck_q;
        mosi_d = mosi_q;
        tx_d   = tx_q;
        rx_d   = rx_q;
        div_d  = div_q;
        bits_d = bits_q;
        if (start) begin
            busy_d = 1'b1;
            sck_d  = 1'b0;
            div_d  = '0;
            bits_d = len;
            tx_d   = tx_word;
            mosi_d = tx_word[23];
        end else if (busy_q) begin
            if (div_q != DIV_LAST) begin
                div_d = div_q + DIV_W'(1);
            end else begin
                div_d = '0;
                if (!sck_q) begin
                    sck_d = 1'b1;
                    rx_d  = {rx_q[6:0], spi_miso};
                end else begin
                    sck_d = 1'b0;
                    if (bits_q == 5'd1) begin
                        busy_d = 1'b0;
                    end else begin
                        bits_d = bits_q - 5'd1;
                        tx_d   = {tx_q[22:0], 1'b0};
                        mosi_d = tx_q[22];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            busy_q <= 1'b0;
            sck_q  <= 1'b0;
            mosi_q <= 1'b0;
            tx_q   <= '0;
            rx_q   <= '0;
            div_q  <= '0;
            bits_q <= '0;
        end else begin
            busy_q <= busy_d;
            sck_q  <= sck_d;
            mosi_q <= mosi_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            div_q  <= div_d;
            bits_q <= bits_d;
        end
    end

endmodule

// File: rtl/spi_flash_fetch.sv
// Fetches program bytes from SPI NOR flash (READ 0x03) for the core's PC,
// streaming sequential addresses without re-issuing the command.
module spi_flash_fetch
    import spi_flash_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int CLK_DIV     = 2,
    parameter int CS_MIN_HIGH = 4
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [ADDR_WIDTH-1:0] pc_addr,
    output logic [7:0]            flash_data,
    output logic                  flash_ready,
    output logic                  spi_cs_n,
    output logic                  spi_sck,
    output logic                  spi_mosi,
    input  logic                  spi_miso
);

    localparam int             GAP_W    = (CS_MIN_HIGH > 1) ? $clog2(CS_MIN_HIGH) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_MIN_HIGH - 1);

    fetch_state_e           state_q, state_d;
    logic [GAP_W-1:0]       gap_q, gap_d;
    logic [ADDR_WIDTH-1:0]  lat_q, lat_d;
    logic                   valid_q, valid_d;
    logic [7:0]             data_q, data_d;
    logic                   cs_n_q, cs_n_d;

    logic                   eng_start;
    logic [4:0]             eng_len;
    logic [23:0]            eng_tx;
    logic                   eng_done;
    logic [7:0]             eng_rx;
    logic [ADDR_WIDTH-1:0]  lat_inc;
    logic                   is_seq;
    logic                   redirect;

    assign lat_inc     = lat_q + ADDR_WIDTH'(1);
    assign is_seq      = (pc_addr == lat_inc) && (lat_q != '1);
    assign flash_ready = valid_q && (pc_addr == lat_q);
    assign flash_data  = data_q;
    assign spi_cs_n    = cs_n_q;

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV)
    ) u_engine (
        .clk      (clk),
        .arst_n   (arst_n),
        .start    (eng_start),
        .len      (eng_len),
        .tx_word  (eng_tx),
        .spi_miso (spi_miso),
        .spi_sck  (spi_sck),
        .spi_mosi (spi_mosi),
        .done     (eng_done),
        .rx_byte  (eng_rx)
    );

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        lat_d     = lat_q;
        valid_d   = valid_q;
        data_d    = data_q;
        cs_n_d    = cs_n_q;
        eng_start = 1'b0;
        eng_len   = 5'd8;
        eng_tx    = '0;
        redirect  = 1'b0;
        case (state_q)
            CS_GAP: begin
                cs_n_d = 1'b1;
                if (gap_q == GAP_LAST) begin
                    gap_d     = '0;
                    lat_d     = pc_addr;
                    cs_n_d    = 1'b0;
                    eng_start = 1'b1;
                    eng_tx    = {SPI_READ_CMD, 16'h0000};
                    state_d   = CMD;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            CMD: begin
                if (eng_done) begin
                    eng_start = 1'b1;
                    eng_len   = 5'd24;
                    eng_tx    = FLASH_ADDR_BITS'(lat_q);
                    state_d   = ADDR;
                end
            end
            ADDR: begin
                if (eng_done) begin
                    eng_start = 1'b1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (eng_done) begin
                    data_d = eng_rx;
                    if (pc_addr == lat_q) begin
                        valid_d = 1'b1;
                        state_d = HOLD;
                    end else begin
                        redirect = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (pc_addr != lat_q) begin
                    redirect = 1'b1;
                end
            end
            default: begin
                state_d = CS_GAP;
                cs_n_d  = 1'b1;
                gap_d   = '0;
            end
        endcase

        // The PC moved away from the latched address: continue the stream or restart
        if (redirect) begin
            valid_d = 1'b0;
            if (is_seq) begin
                lat_d     = pc_addr;
                eng_start = 1'b1;
                eng_len   = 5'd8;
                eng_tx    = '0;
                state_d   = DATA;
            end else begin
                cs_n_d  = 1'b1;
                gap_d   = '0;
                state_d = CS_GAP;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= CS_GAP;
            gap_q   <= '0;
            lat_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            cs_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            lat_q   <= lat_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cs_n_q  <= cs_n_d;
        end
    end

endmodule

// File: tb/tb_spi_flash_fetch.sv
// Scoreboard bench for spi_flash_fetch with a behavioural SPI NOR flash model.
module tb_spi_flash_fetch;

    localparam int CS_MIN_HIGH = 4;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [11:0] pc_addr = 12'h000;
    logic [7:0]  flash_data;
    logic        flash_ready;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso = 1'b0;

    int total = 0;
    int bad   = 0;

    logic [19:0] exp_rdy_q[$];  // {addr, data}
    logic [31:0] exp_cmd_q[$];  // {cmd, 24-bit addr}

    int sck_rises = 0;
    int cs_rises  = 0;

    spi_flash_fetch #(
        .ADDR_WIDTH  (12),
        .CLK_DIV     (2),
        .CS_MIN_HIGH (CS_MIN_HIGH)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .pc_addr     (pc_addr),
        .flash_data  (flash_data),
        .flash_ready (flash_ready),
        .spi_cs_n    (spi_cs_n),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] flash_mem(input logic [11:0] a);
        case (a)
            12'h7FF: return 8'h11;
            12'h123: return 8'hA5;
            12'h124: return 8'h3C;
            12'h200: return 8'h77;
            12'hFFF: return 8'hE1;
            12'h000: return 8'h0F;
            12'h010: return 8'h42;
            12'h011: return 8'h99;
            12'h050: return 8'hC8;
            12'h300: return 8'h5D;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end else begin
            $display("ok   %s = %0h", name, got);
        end
    endtask

    // Flash model: capture command+address, then stream bytes on SCK falling edges
    int          fbits = 0;
    logic [31:0] fshift = '0;
    always @(posedge spi_sck or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            fbits = 0;
        end else begin
            sck_rises++;
            if (fbits < 32) fshift = {fshift[30:0], spi_mosi};
            fbits++;
            if (fbits == 32) begin
                total++;
                if (exp_cmd_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_cmd got=%08h exp=none", fshift);
                end else begin
                    logic [31:0] e;
                    e = exp_cmd_q.pop_front();
                    if (fshift != e) begin
                        bad++;
                        $display("FAIL cmd_bytes got=%08h exp=%08h", fshift, e);
                    end else begin
                        $display("ok   cmd_bytes = %08h", fshift);
                    end
                end
            end
        end
    end

    always @(negedge spi_sck) begin
        if (!spi_cs_n && fbits >= 32) begin
            logic [7:0]  b;
            logic [11:0] a;
            int          idx;
            a        = fshift[11:0] + 12'((fbits - 32) / 8);
            b        = flash_mem(a);
            idx      = 7 - ((fbits - 32) % 8);
            spi_miso = b[idx];
        end
    end

    always @(posedge spi_cs_n) cs_rises++;

    // CS high time between transactions
    int hi_cnt = 0;
    always @(negedge clk) begin
        if (spi_cs_n) begin
            hi_cnt++;
        end else begin
            if (hi_cnt > 0) begin
                total++;
                if (hi_cnt < CS_MIN_HIGH) begin
                    bad++;
                    $display("FAIL cs_high_gap got=%0d exp>=%0d", hi_cnt, CS_MIN_HIGH);
                end
            end
            hi_cnt = 0;
        end
    end

    // Ready monitor: every rising flash_ready must match the next expected fetch
    logic ready_prev = 1'b0;
    always @(negedge clk) begin
        if (flash_ready && !ready_prev) begin
            total++;
            if (exp_rdy_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_ready got=%03h/%02h exp=none", pc_addr, flash_data);
            end else begin
                logic [19:0] e;
                e = exp_rdy_q.pop_front();
                if ({pc_addr, flash_data} != e) begin
                    bad++;
                    $display("FAIL ready_data got=%03h/%02h exp=%03h/%02h",
                             pc_addr, flash_data, e[19:8], e[7:0]);
                end else begin
                    $display("ok   ready addr=%03h data=%02h", pc_addr, flash_data);
                end
            end
        end
        ready_prev = flash_ready;
    end

    task automatic wait_ready(input string name, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!flash_ready && cycles < 1000);
        if (!flash_ready) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got=%0d exp=ready", name, cycles);
        end
    endtask

    task automatic wait_rises(input int base, input int n);
        int c;
        c = 0;
        while ((sck_rises - base) < n && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if ((sck_rises - base) < n) begin
            total++;
            bad++;
            $display("FAIL rise_timeout got=%0d exp=%0d", sck_rises - base, n);
        end
    endtask

    task automatic set_pc(input logic [11:0] a);
        @(posedge clk);
        #1;
        pc_addr = a;
    endtask

    initial begin
        int lat;
        int r0;
        int c0;

        // Reset hold
        pc_addr = 12'h7FF;
        repeat (5) @(negedge clk);
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sck", spi_sck, 0);
        check("rst_ready", flash_ready, 0);
        check("rst_data", flash_data, 8'h00);
        exp_cmd_q.push_back(32'h030007FF);
        exp_rdy_q.push_back({12'h7FF, 8'h11});
        arst_n = 1'b1;
        wait_ready("first", lat);

        // Fresh fetch latency and bit count
        r0 = sck_rises;
        exp_cmd_q.push_back(32'h03000123);
        exp_rdy_q.push_back({12'h123, 8'hA5});
        set_pc(12'h123);
        wait_ready("fresh", lat);
        check("fresh_latency", lat, 165);
        check("fresh_sck_rises", sck_rises - r0, 40);

        // Sequential stream
        r0 = sck_rises;
        c0 = cs_rises;
        exp_rdy_q.push_back({12'h124, 8'h3C});
        set_pc(12'h124);
        wait_ready("seq", lat);
        check("seq_latency", lat, 33);
        check("seq_sck_rises", sck_rises - r0, 8);
        check("seq_cs_rises", cs_rises - c0, 0);

        // Jump: ready drops immediately
        exp_cmd_q.push_back(32'h03000200);
        exp_rdy_q.push_back({12'h200, 8'h77});
        set_pc(12'h200);
        #1;
        check("jump_ready_drop", flash_ready, 0);
        wait_ready("jump", lat);

        // Wrap 0xFFF -> 0x000 is a full restart
        exp_cmd_q.push_back(32'h03000FFF);
        exp_rdy_q.push_back({12'hFFF, 8'hE1});
        set_pc(12'hFFF);
        wait_ready("top", lat);
        c0 = cs_rises;
        exp_cmd_q.push_back(32'h03000000);
        exp_rdy_q.push_back({12'h000, 8'h0F});
        set_pc(12'h000);
        wait_ready("wrap", lat);
        check("wrap_cs_rises", cs_rises - c0, 1);
        check("wrap_latency", lat, 165);

        // Sequential change during ADDR phase
        exp_cmd_q.push_back(32'h03000010);
        r0 = sck_rises;
        set_pc(12'h010);
        wait_rises(r0, 12);
        r0 = sck_rises;
        c0 = cs_rises;
        exp_rdy_q.push_back({12'h011, 8'h99});
        pc_addr = 12'h011;
        wait_ready("mid_addr", lat);
        check("mid_addr_cs_rises", cs_rises - c0, 0);
        check("mid_addr_sck_rises", sck_rises - r0, 36);

        // Non-sequential change during DATA phase
        exp_cmd_q.push_back(32'h03000010);
        r0 = sck_rises;
        set_pc(12'h010);
        wait_rises(r0, 35);
        c0 = cs_rises;
        exp_cmd_q.push_back(32'h03000050);
        exp_rdy_q.push_back({12'h050, 8'hC8});
        pc_addr = 12'h050;
        wait_ready("mid_data", lat);
        check("mid_data_cs_rises", cs_rises - c0, 1);

        // Reset in the middle of ADDR
        r0 = sck_rises;
        set_pc(12'h300);
        wait_rises(r0, 16);
        #3;
        arst_n = 1'b0;
        #1;
        check("mid_rst_cs_n", spi_cs_n, 1);
        check("mid_rst_sck", spi_sck, 0);
        check("mid_rst_ready", flash_ready, 0);
        repeat (3) @(negedge clk);
        exp_cmd_q.push_back(32'h03000300);
        exp_rdy_q.push_back({12'h300, 8'h5D});
        arst_n = 1'b1;
        wait_ready("post_rst", lat);
        check("post_rst_full_fetch", int'(lat > 160), 1);

        repeat (10) @(posedge clk);
        check("cmd_queue_left", exp_cmd_q.size(), 0);
        check("ready_queue_left", exp_rdy_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
